// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the MIPS-subset CPU: a registered IF/ID/EXE/MEM/WB
// sequencer that drives datapath strobes combinationally from (state, opcode, zero).
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16,
    parameter logic [OPCODE_W-1:0] HALT_OP = OPCODE_W'(6'b111111)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                PCWre,
    output logic                IRWre,
    output logic                InsMemRW,
    output logic                ExtSel,
    output logic                RegOut,
    output logic                RegWre,
    output logic                ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSrc,
    output logic                DataMemRW,
    output logic                DataMemRD,
    output logic                ALUM2Reg,
    output logic [2:0]          state,
    output logic                halted,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b000001);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_MOVE = OPCODE_W'(6'b000110);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b000111);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b001001);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b111000);

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t             state_q, state_d;
    logic               illegal_q;
    logic               setIllegal;
    logic [CNT_W-1:0]   cnt_q;

    logic               isAlu, isSw, isLw, isBeq, isBne, isJ, isHalt, isLegal;
    logic [ALUOP_W-1:0] decAluOp;
    logic               decSrcB, decExt, decRegOut, decM2R;
    logic               fieldsActive;

    // Opcode classification and per-instruction datapath fields.
    always_comb begin
        isAlu     = 1'b0;
        isSw      = 1'b0;
        isLw      = 1'b0;
        isBeq     = 1'b0;
        isBne     = 1'b0;
        decAluOp  = '0;
        decSrcB   = 1'b0;
        decExt    = 1'b0;
        decRegOut = 1'b0;
        decM2R    = 1'b0;
        case (opcode)
            OP_ADD, OP_MOVE: begin
                isAlu = 1'b1; decRegOut = 1'b1;
            end
            OP_ADDI: begin
                isAlu = 1'b1; decSrcB = 1'b1; decExt = 1'b1;
            end
            OP_SUB: begin
                isAlu = 1'b1; decAluOp = ALUOP_W'(3'b001); decRegOut = 1'b1;
            end
            OP_ORI: begin
                isAlu = 1'b1; decAluOp = ALUOP_W'(3'b011); decSrcB = 1'b1;
            end
            OP_AND: begin
                isAlu = 1'b1; decAluOp = ALUOP_W'(3'b100); decRegOut = 1'b1;
            end
            OP_OR: begin
                isAlu = 1'b1; decAluOp = ALUOP_W'(3'b011); decRegOut = 1'b1;
            end
            OP_SW: begin
                isSw = 1'b1; decSrcB = 1'b1; decExt = 1'b1;
            end
            OP_LW: begin
                isLw = 1'b1; decSrcB = 1'b1; decExt = 1'b1; decM2R = 1'b1;
            end
            OP_BEQ: begin
                isBeq = 1'b1; decAluOp = ALUOP_W'(3'b001); decExt = 1'b1;
            end
            OP_BNE: begin
                isBne = 1'b1; decAluOp = ALUOP_W'(3'b001); decExt = 1'b1;
            end
            default: ;
        endcase
    end

    assign isJ     = (opcode == OP_J);
    assign isHalt  = (opcode == HALT_OP);
    assign isLegal = isAlu | isSw | isLw | isBeq | isBne | isJ | isHalt;

    // Decode fields are only meaningful while an instruction is in flight.
    assign fieldsActive = (state_q == S_ID) || (state_q == S_EXE) ||
                          (state_q == S_MEM) || (state_q == S_WB);
    assign ALUOp    = fieldsActive ? decAluOp  : '0;
    assign ALUSrcB  = fieldsActive & decSrcB;
    assign ExtSel   = fieldsActive & decExt;
    assign RegOut   = fieldsActive & decRegOut;
    assign ALUM2Reg = fieldsActive & decM2R;

    // Per-state strobes and next-state selection.
    always_comb begin
        state_d    = state_q;
        PCWre      = 1'b0;
        IRWre      = 1'b0;
        InsMemRW   = 1'b0;
        RegWre     = 1'b0;
        PCSrc      = PC_NEXT;
        DataMemRW  = 1'b0;
        DataMemRD  = 1'b0;
        setIllegal = 1'b0;
        case (state_q)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                if (isJ) begin
                    PCWre   = 1'b1;
                    PCSrc   = PC_JUMP;
                    state_d = S_IF;
                end else if (isHalt) begin
                    state_d = S_HALT;
                end else if (!isLegal) begin
                    PCWre      = 1'b1;
                    setIllegal = 1'b1;
                    state_d    = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (isBeq || isBne) begin
                    PCWre   = 1'b1;
                    PCSrc   = ((isBeq && zero) || (isBne && !zero)) ? PC_BRANCH : PC_NEXT;
                    state_d = S_IF;
                end else if (isSw || isLw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (isSw) begin
                    DataMemRW = 1'b1;
                    PCWre     = 1'b1;
                    state_d   = S_IF;
                end else begin
                    DataMemRD = isLw;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                RegWre  = 1'b1;
                PCWre   = 1'b1;
                state_d = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Every PCWre cycle marks exactly one retired instruction.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (setIllegal) begin
                illegal_q <= 1'b1;
            end
            if (PCWre) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign illegal_op  = illegal_q;
    assign retired_cnt = cnt_q;

endmodule
